// File: rtl/csi2_frame_ctrl_if.sv
// AXI4-Stream bundle shared by the CSI-2 packet input and the pixel-line output.
// There is no tready: the sink always accepts.
interface axi4_stream_if #(
    parameter int DW = 32,
    parameter int UW = 1
);
    logic              tvalid;
    logic [DW-1:0]     tdata;
    logic [DW/8-1:0]   tstrb;
    logic [DW/8-1:0]   tkeep;
    logic              tlast;
    logic [UW-1:0]     tuser;

    modport master (output tvalid, tdata, tstrb, tkeep, tlast, tuser);
    modport slave  (input  tvalid, tdata, tstrb, tkeep, tlast, tuser);
endinterface

// File: rtl/csi2_frame_ctrl.sv
// CSI-2 frame sequencer: decodes packet headers, tracks FS/FE, forwards one pixel line per packet.
// Optional build macro CSI2_VC_FILTER_EN restricts decoding to virtual channel VC.
module csi2_frame_ctrl #(
    parameter logic [5:0] DATA_TYPE = 6'h2B,
    parameter logic [1:0] VC        = 2'd0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    axi4_stream_if.slave  pkt_i,
    input  logic          enable_i,
    axi4_stream_if.master video_o,
    output logic [15:0]   frame_cnt_o,
    output logic [15:0]   line_cnt_o,
    output logic [15:0]   lines_per_frame_o,
    output logic          in_frame_o,
    output logic [2:0]    err_o,
    output logic [1:0]    state_o
);

    // Handshake: a beat transfers on every cycle with tvalid=1; neither side can stall.
    typedef enum logic [1:0] {
        ST_HDR     = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] rem_q;
    logic        sof_q;

    logic [5:0]  hdr_dt;
    logic [1:0]  hdr_vc;
    logic [15:0] hdr_wc;
    logic        vc_ok;
    logic        is_short;
    logic        hdr_beat;
    logic        pay_beat;
    logic        rem_small;
    logic        long_match;
    logic        fs_hit;
    logic        fe_hit;

    logic        emit_d;
    logic [3:0]  strb_d;
    logic        last_d;
    logic [2:0]  err_d;
    logic        line_done;
    logic        fs_start;
    logic        fs_restart;
    logic        fe_done;

    assign hdr_dt = pkt_i.tdata[5:0];
    assign hdr_vc = pkt_i.tdata[7:6];
    assign hdr_wc = pkt_i.tdata[23:8];

`ifdef CSI2_VC_FILTER_EN
    assign vc_ok = (hdr_vc == VC);
`else
    // VC field is decoded but every channel is accepted.
    assign vc_ok = 1'b1 | (hdr_vc == VC);
`endif

    assign is_short   = (hdr_dt < 6'h10);
    assign hdr_beat   = pkt_i.tvalid && (state_q == ST_HDR);
    assign pay_beat   = pkt_i.tvalid && (state_q == ST_PAYLOAD);
    assign rem_small  = (rem_q <= 16'd4);
    assign long_match = !is_short && (hdr_dt == DATA_TYPE) && in_frame_o
                        && (hdr_wc != 16'd0) && vc_ok;
    assign fs_hit     = hdr_beat && is_short && vc_ok && (hdr_dt == 6'h00);
    assign fe_hit     = hdr_beat && is_short && vc_ok && (hdr_dt == 6'h01);
    assign state_o    = state_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_HDR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (pkt_i.tvalid) begin
            case (state_q)
                ST_HDR: begin
                    if (is_short) begin
                        state_d = ST_HDR;
                    end else if (long_match) begin
                        state_d = ST_PAYLOAD;
                    end else if (!pkt_i.tlast) begin
                        state_d = ST_DISCARD;
                    end
                end
                ST_PAYLOAD: begin
                    if (rem_small) begin
                        // Pixels done; a beat without tlast still has the CRC to drop.
                        state_d = pkt_i.tlast ? ST_HDR : ST_DISCARD;
                    end else if (pkt_i.tlast) begin
                        state_d = ST_HDR;
                    end
                end
                ST_DISCARD: begin
                    if (pkt_i.tlast) begin
                        state_d = ST_HDR;
                    end
                end
                default: state_d = ST_HDR;
            endcase
        end
    end

    always_comb begin
        emit_d     = 1'b0;
        strb_d     = 4'h0;
        last_d     = 1'b0;
        err_d      = 3'b000;
        line_done  = 1'b0;
        fs_start   = 1'b0;
        fs_restart = 1'b0;
        fe_done    = 1'b0;

        if (fs_hit) begin
            if (in_frame_o) begin
                fs_restart = 1'b1;
                err_d[0]   = 1'b1;
            end else if (enable_i) begin
                fs_start = 1'b1;
            end
        end

        if (fe_hit) begin
            if (in_frame_o) begin
                fe_done = 1'b1;
            end else begin
                err_d[1] = 1'b1;
            end
        end

        if (pay_beat) begin
            emit_d = 1'b1;
            if (rem_small) begin
                for (int i = 0; i < 4; i++) begin
                    strb_d[i] = (16'(i) < rem_q);
                end
                last_d    = 1'b1;
                line_done = 1'b1;
            end else if (pkt_i.tlast) begin
                strb_d   = pkt_i.tstrb;
                last_d   = 1'b1;
                err_d[2] = 1'b1;
            end else begin
                strb_d = 4'hF;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rem_q             <= 16'd0;
            sof_q             <= 1'b0;
            in_frame_o        <= 1'b0;
            line_cnt_o        <= 16'd0;
            frame_cnt_o       <= 16'd0;
            lines_per_frame_o <= 16'd0;
            err_o             <= 3'b000;
            video_o.tvalid    <= 1'b0;
            video_o.tdata     <= 32'd0;
            video_o.tstrb     <= 4'h0;
            video_o.tkeep     <= 4'h0;
            video_o.tlast     <= 1'b0;
            video_o.tuser     <= 1'b0;
        end else begin
            if (hdr_beat && long_match) begin
                rem_q <= hdr_wc;
            end else if (pay_beat && !rem_small) begin
                rem_q <= rem_q - 16'd4;
            end

            if (fs_start) begin
                in_frame_o <= 1'b1;
            end else if (fe_done) begin
                in_frame_o <= 1'b0;
            end

            if (fs_start || fs_restart) begin
                line_cnt_o <= 16'd0;
            end else if (line_done) begin
                line_cnt_o <= line_cnt_o + 16'd1;
            end

            if (fe_done) begin
                frame_cnt_o       <= frame_cnt_o + 16'd1;
                lines_per_frame_o <= line_cnt_o;
            end

            // SOF rides on the first emitted beat after it is armed.
            if (fs_start || fs_restart) begin
                sof_q <= 1'b1;
            end else if (emit_d) begin
                sof_q <= 1'b0;
            end

            err_o          <= err_d;
            video_o.tvalid <= emit_d;
            video_o.tlast  <= last_d;
            video_o.tuser  <= emit_d & sof_q;
            if (emit_d) begin
                video_o.tdata <= pkt_i.tdata;
                video_o.tstrb <= strb_d;
                video_o.tkeep <= strb_d;
            end
        end
    end

endmodule

// File: tb/tb_csi2_frame_ctrl.sv
// Directed bench for csi2_frame_ctrl: stimulus pushes expected beats/errors, a monitor pops and compares.
module tb_csi2_frame_ctrl;

`ifdef CSI2_VC_FILTER_EN
    localparam logic [1:0] TB_VC = 2'd1;
`else
    localparam logic [1:0] TB_VC = 2'd0;
`endif

    logic        clk;
    logic        rst;
    logic        enable;
    logic [15:0] frame_cnt;
    logic [15:0] line_cnt;
    logic [15:0] lines_per_frame;
    logic        in_frame;
    logic [2:0]  err;
    logic [1:0]  state;

    axi4_stream_if #(.DW(32), .UW(1)) pkt_if ();
    axi4_stream_if #(.DW(32), .UW(1)) vid_if ();

    csi2_frame_ctrl #(.DATA_TYPE(6'h2B), .VC(TB_VC)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .pkt_i             (pkt_if),
        .enable_i          (enable),
        .video_o           (vid_if),
        .frame_cnt_o       (frame_cnt),
        .line_cnt_o        (line_cnt),
        .lines_per_frame_o (lines_per_frame),
        .in_frame_o        (in_frame),
        .err_o             (err),
        .state_o           (state)
    );

    int n_pass  = 0;
    int n_total = 0;

    // {tdata, tstrb, tkeep, tlast, tuser}
    logic [41:0] exp_q[$];
    logic [2:0]  err_q[$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] s, input logic l);
        pkt_if.tvalid = 1'b1;
        pkt_if.tdata  = d;
        pkt_if.tstrb  = s;
        pkt_if.tlast  = l;
        @(posedge clk);
        #1;
        pkt_if.tvalid = 1'b0;
        pkt_if.tlast  = 1'b0;
    endtask

    function automatic logic [31:0] hdr(input logic [5:0] dt, input logic [1:0] vc,
                                        input logic [15:0] wc);
        return {8'h00, wc, vc, dt};
    endfunction

    task automatic short_pkt(input logic [5:0] dt, input logic [1:0] vc);
        send_beat(hdr(dt, vc, 16'h0000), 4'hF, 1'b1);
    endtask

    task automatic long_pkt(input logic [5:0] dt, input logic [1:0] vc, input logic [15:0] wc,
                            input int n, input logic [31:0] base, input logic [3:0] last_strb);
        send_beat(hdr(dt, vc, wc), 4'hF, 1'b0);
        for (int i = 0; i < n; i++) begin
            send_beat(base + 32'(i), (i == n - 1) ? last_strb : 4'hF, i == n - 1);
        end
    endtask

    task automatic push_beat(input logic [31:0] d, input logic [3:0] s, input logic l,
                             input logic u);
        exp_q.push_back({d, s, s, l, u});
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [41:0] act;
        logic [41:0] expv;
        logic [2:0]  eexp;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (vid_if.tvalid) begin
                    act = {vid_if.tdata, vid_if.tstrb, vid_if.tkeep, vid_if.tlast, vid_if.tuser};
                    n_total++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL video_unexpected act=%h exp=none", act);
                    end else begin
                        expv = exp_q.pop_front();
                        if (act === expv) n_pass++;
                        else $display("FAIL video_beat act=%h exp=%h", act, expv);
                    end
                end
                if (err !== 3'b000) begin
                    n_total++;
                    if (err_q.size() == 0) begin
                        $display("FAIL err_unexpected act=%b exp=none", err);
                    end else begin
                        eexp = err_q.pop_front();
                        if (err === eexp) n_pass++;
                        else $display("FAIL err_pulse act=%b exp=%b", err, eexp);
                    end
                end
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        rst           = 1'b1;
        enable        = 1'b0;
        pkt_if.tvalid = 1'b0;
        pkt_if.tdata  = 32'd0;
        pkt_if.tstrb  = 4'h0;
        pkt_if.tkeep  = 4'hF;
        pkt_if.tlast  = 1'b0;
        pkt_if.tuser  = 1'b0;
        idle(3);

        check("rst_tvalid", 32'(vid_if.tvalid), 32'd0);
        check("rst_tdata", vid_if.tdata, 32'd0);
        check("rst_tstrb", 32'(vid_if.tstrb), 32'd0);
        check("rst_tlast", 32'(vid_if.tlast), 32'd0);
        check("rst_tuser", 32'(vid_if.tuser), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_line_cnt", 32'(line_cnt), 32'd0);
        check("rst_lpf", 32'(lines_per_frame), 32'd0);
        check("rst_in_frame", 32'(in_frame), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_state", 32'(state), 32'd0);

        rst    = 1'b0;
        enable = 1'b1;
        idle(1);

        // Frame 1: WC 10 -> strobes F, F, 3 with SOF on the first beat.
        short_pkt(6'h00, TB_VC);
        idle(2);
        check("fs_in_frame", 32'(in_frame), 32'd1);
        push_beat(32'h1111_0000, 4'hF, 1'b0, 1'b1);
        push_beat(32'h1111_0001, 4'hF, 1'b0, 1'b0);
        push_beat(32'h1111_0002, 4'h3, 1'b1, 1'b0);
        long_pkt(6'h2B, TB_VC, 16'd10, 3, 32'h1111_0000, 4'hF);
        idle(2);
        check("wc10_line_cnt", 32'(line_cnt), 32'd1);
        short_pkt(6'h01, TB_VC);
        idle(2);
        check("fe1_frame_cnt", 32'(frame_cnt), 32'd1);
        check("fe1_lpf", 32'(lines_per_frame), 32'd1);
        check("fe1_in_frame", 32'(in_frame), 32'd0);

        // Frame 2: WC 12 -> three full beats, CRC-only beat dropped.
        short_pkt(6'h00, TB_VC);
        push_beat(32'h2222_0000, 4'hF, 1'b0, 1'b1);
        push_beat(32'h2222_0001, 4'hF, 1'b0, 1'b0);
        push_beat(32'h2222_0002, 4'hF, 1'b1, 1'b0);
        long_pkt(6'h2B, TB_VC, 16'd12, 4, 32'h2222_0000, 4'hF);
        idle(2);
        check("wc12_line_cnt", 32'(line_cnt), 32'd1);
        check("wc12_state", 32'(state), 32'd0);

        // FS inside a frame restarts it; then FE, then a stray FE.
        err_q.push_back(3'b001);
        short_pkt(6'h00, TB_VC);
        idle(2);
        check("refs_line_cnt", 32'(line_cnt), 32'd0);
        check("refs_in_frame", 32'(in_frame), 32'd1);
        short_pkt(6'h01, TB_VC);
        idle(2);
        check("fe2_frame_cnt", 32'(frame_cnt), 32'd2);
        check("fe2_lpf", 32'(lines_per_frame), 32'd0);
        err_q.push_back(3'b010);
        short_pkt(6'h01, TB_VC);
        idle(2);
        check("stray_fe_frame_cnt", 32'(frame_cnt), 32'd2);

        // Truncated WC 16 packet: input tlast on payload beat 2.
        short_pkt(6'h00, TB_VC);
        push_beat(32'h3333_0000, 4'hF, 1'b0, 1'b1);
        push_beat(32'h3333_0001, 4'h3, 1'b1, 1'b0);
        err_q.push_back(3'b100);
        long_pkt(6'h2B, TB_VC, 16'd16, 2, 32'h3333_0000, 4'h3);
        idle(2);
        check("trunc_line_cnt", 32'(line_cnt), 32'd0);
        check("trunc_state", 32'(state), 32'd0);

        // Other data type is dropped; WC 4 (rem == 4 boundary) follows back-to-back.
        long_pkt(6'h2A, TB_VC, 16'd10, 3, 32'hDEAD_0000, 4'hF);
        push_beat(32'h4444_0000, 4'hF, 1'b1, 1'b0);
        long_pkt(6'h2B, TB_VC, 16'd4, 2, 32'h4444_0000, 4'hF);
        idle(2);
        check("wc4_line_cnt", 32'(line_cnt), 32'd1);
        short_pkt(6'h01, TB_VC);
        idle(2);
        check("fe3_frame_cnt", 32'(frame_cnt), 32'd3);
        check("fe3_lpf", 32'(lines_per_frame), 32'd1);

        // Matching long packet outside a frame produces nothing.
        long_pkt(6'h2B, TB_VC, 16'd10, 3, 32'hBEEF_0000, 4'hF);
        idle(2);
        check("outside_line_cnt", 32'(line_cnt), 32'd1);

        // enable_i low blocks a new FS but not a running frame.
        enable = 1'b0;
        short_pkt(6'h00, TB_VC);
        idle(2);
        check("disabled_fs", 32'(in_frame), 32'd0);
        enable = 1'b1;
        short_pkt(6'h00, TB_VC);
        enable = 1'b0;
        push_beat(32'h5555_0000, 4'hF, 1'b1, 1'b1);
        long_pkt(6'h2B, TB_VC, 16'd4, 2, 32'h5555_0000, 4'hF);
        short_pkt(6'h01, TB_VC);
        idle(2);
        check("midframe_disable_frame_cnt", 32'(frame_cnt), 32'd4);
        check("midframe_disable_lpf", 32'(lines_per_frame), 32'd1);
        enable = 1'b1;

`ifdef CSI2_VC_FILTER_EN
        short_pkt(6'h00, 2'd0);
        idle(2);
        check("vc0_fs_in_frame", 32'(in_frame), 32'd0);
        short_pkt(6'h00, 2'd1);
        idle(2);
        check("vc1_fs_in_frame", 32'(in_frame), 32'd1);
        short_pkt(6'h01, 2'd1);
        idle(2);
`endif

        idle(4);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("err_q_drained", 32'(err_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
